zap_copro_arbiter: RTL and testbench

Routes coprocessor transactions from the predecode coprocessor stage to one of `NUM_CP` attached coprocessors. Selection uses the coprocessor-number field of the instruction. The block sequences each transaction through dispatch, wait and completion, and answers the predecode stage with a done handshake. When no coprocessor accepts the instruction, either because none is mapped or because the response times out, the block flags it as undefined. It sits between predecode (`o_copro_*_ff` / `i_copro_done`) and the coprocessor ports, for example CP15.

---
 rtl/zap_copro_pkg.sv | 31 +++
 rtl/zap_copro_id_match.sv | 36 +++
 rtl/zap_copro_arbiter.sv | 171 +++++++++++++++++
 tb/tb_zap_copro_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_copro_pkg.sv
// ---------------------------------------------------------------------------
// zap_copro_pkg
// Shared definitions for the coprocessor arbiter:
//   - state_t       : arbiter FSM encoding (IDLE=0, WAIT=1, RESP=2)
//   - CP_ID_W       : width of the coprocessor-number field
//   - CP_NUM_LSB/MSB: position of that field in the instruction word
//   - cp_num()      : extracts the coprocessor number from an instruction
//   - cnt_width()   : timeout counter width, never narrower than one bit
// ---------------------------------------------------------------------------
package zap_copro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CP_ID_W    = 4;
  localparam int CP_NUM_LSB = 8;
  localparam int CP_NUM_MSB = CP_NUM_LSB + CP_ID_W - 1;

  function automatic logic [CP_ID_W-1:0] cp_num(input logic [31:0] word);
    return word[CP_NUM_MSB:CP_NUM_LSB];
  endfunction

  // A timeout of 0 disables the counter's purpose but keeps a legal width.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/zap_copro_id_match.sv
// ---------------------------------------------------------------------------
// zap_copro_id_match
// Combinational priority match of a coprocessor number against the table of
// attached coprocessor numbers. The lowest matching port index wins.
// Ports:
//   cp_id : coprocessor number taken from the instruction
//   sel   : one-hot selection of the winning port (all zero on a miss)
//   hit   : at least one port carries this coprocessor number
// ---------------------------------------------------------------------------
module zap_copro_id_match
  import zap_copro_pkg::*;
#(
  parameter int                      NUM_CP = 2,
  parameter logic [NUM_CP*4-1:0]     CP_IDS = {4'd14, 4'd15}
) (
  input  logic [CP_ID_W-1:0] cp_id,
  output logic [NUM_CP-1:0]  sel,
  output logic               hit
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise synthesis infers a latch.
  always_comb begin
    sel = '0;
    // Walk from the top index down so the lowest matching index is the
    // last one written and therefore wins.
    for (int k = NUM_CP - 1; k >= 0; k--) begin
      if (CP_IDS[CP_ID_W*k +: CP_ID_W] == cp_id) begin
        sel    = '0;
        sel[k] = 1'b1;
      end
    end
    hit = |sel;
  end

endmodule

// File: rtl/zap_copro_arbiter.sv
// ---------------------------------------------------------------------------
// zap_copro_arbiter
// Routes a coprocessor instruction from the predecode stage to the attached
// coprocessor whose number matches bits [11:8] of the instruction, waits for
// its completion (or a timeout) and answers predecode with done/undef.
// Ports:
//   i_clk, i_reset_n      : clock, asynchronous active-low reset
//   i_flush               : pipeline clear; aborts any transaction
//   i_copro_dav           : transaction pending from predecode
//   i_copro_word/reg/mode : instruction, physical register, CPSR snapshot
//   o_copro_done          : completion to predecode (held until dav drops)
//   o_copro_undef         : qualifies done; instruction not accepted
//   o_cp_dav              : one-hot request to coprocessor k
//   o_cp_word/reg/mode    : latched transaction, broadcast to all ports
//   o_cp_flush            : one-cycle abort to the coprocessors
//   i_cp_done             : completion from coprocessor k
// All outputs are registered.
// ---------------------------------------------------------------------------
module zap_copro_arbiter
  import zap_copro_pkg::*;
#(
  parameter int                  PHY_REGS = 46,
  parameter int                  NUM_CP   = 2,
  parameter logic [NUM_CP*4-1:0] CP_IDS   = {4'd14, 4'd15},
  parameter int                  TIMEOUT  = 255,
  localparam int                 RW       = $clog2(PHY_REGS)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic              i_copro_dav,
  input  logic [31:0]       i_copro_word,
  input  logic [RW-1:0]     i_copro_reg,
  input  logic [31:0]       i_copro_mode,
  output logic              o_copro_done,
  output logic              o_copro_undef,
  output logic [NUM_CP-1:0] o_cp_dav,
  output logic [31:0]       o_cp_word,
  output logic [RW-1:0]     o_cp_reg,
  output logic [31:0]       o_cp_mode,
  output logic              o_cp_flush,
  input  logic [NUM_CP-1:0] i_cp_done
);

  localparam int            CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [NUM_CP-1:0]   cp_dav_nxt;
  logic [31:0]         cp_word_nxt, cp_mode_nxt;
  logic [RW-1:0]       cp_reg_nxt;
  logic                cp_flush_nxt, done_nxt, undef_nxt;

  logic [NUM_CP-1:0]   match_sel;
  logic                match_hit;

  zap_copro_id_match #(
    .NUM_CP (NUM_CP),
    .CP_IDS (CP_IDS)
  ) u_id_match (
    .cp_id (cp_num(i_copro_word)),
    .sel   (match_sel),
    .hit   (match_hit)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      o_cp_dav      <= '0;
      o_cp_word     <= '0;
      o_cp_reg      <= '0;
      o_cp_mode     <= '0;
      o_cp_flush    <= 1'b0;
      o_copro_done  <= 1'b0;
      o_copro_undef <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      o_cp_dav      <= cp_dav_nxt;
      o_cp_word     <= cp_word_nxt;
      o_cp_reg      <= cp_reg_nxt;
      o_cp_mode     <= cp_mode_nxt;
      o_cp_flush    <= cp_flush_nxt;
      o_copro_done  <= done_nxt;
      o_copro_undef <= undef_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cp_dav_nxt   = o_cp_dav;
    cp_word_nxt  = o_cp_word;
    cp_reg_nxt   = o_cp_reg;
    cp_mode_nxt  = o_cp_mode;
    cp_flush_nxt = 1'b0;              // abort is a single-cycle pulse
    done_nxt     = o_copro_done;
    undef_nxt    = o_copro_undef;

    if (i_flush) begin
      // Flush beats everything; coprocessors only need the abort when one
      // of them actually holds a request.
      state_nxt    = ST_IDLE;
      cnt_nxt      = '0;
      cp_dav_nxt   = '0;
      cp_word_nxt  = '0;
      cp_reg_nxt   = '0;
      cp_mode_nxt  = '0;
      cp_flush_nxt = (state == ST_WAIT);
      done_nxt     = 1'b0;
      undef_nxt    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_copro_dav) begin
            cp_word_nxt = i_copro_word;
            cp_reg_nxt  = i_copro_reg;
            cp_mode_nxt = i_copro_mode;
            if (match_hit) begin
              state_nxt  = ST_WAIT;
              cp_dav_nxt = match_sel;
              cnt_nxt    = '0;
            end else begin
              state_nxt  = ST_RESP;
              done_nxt   = 1'b1;
              undef_nxt  = 1'b1;
            end
          end
        end

        ST_WAIT: begin
          // o_cp_dav still holds the one-hot port k, so it masks off
          // completions from coprocessors that were not asked.
          if (|(i_cp_done & o_cp_dav)) begin
            state_nxt  = ST_RESP;
            cp_dav_nxt = '0;
            done_nxt   = 1'b1;
            undef_nxt  = 1'b0;
          end else if ((TIMEOUT != 0) && (cnt == TMO_LAST)) begin
            state_nxt    = ST_RESP;
            cp_dav_nxt   = '0;
            cp_flush_nxt = 1'b1;
            done_nxt     = 1'b1;
            undef_nxt    = 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CW'(1);
          end
        end

        ST_RESP: begin
          // Hold done until predecode, possibly stalled, drops its request.
          if (!i_copro_dav) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b0;
            undef_nxt = 1'b0;
          end
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zap_copro_arbiter.sv
// ---------------------------------------------------------------------------
// tb_zap_copro_arbiter
// Self-checking bench for zap_copro_arbiter (TIMEOUT=4). Each scenario task
// queues the expected post-edge outputs for its stimulus sequence, then
// drives one stimulus per cycle and compares the observed outputs against
// the queue head at the following falling edge.
// ---------------------------------------------------------------------------
module tb_zap_copro_arbiter;

  localparam int PHY_REGS = 46;
  localparam int RW       = $clog2(PHY_REGS);
  localparam int NUM_CP   = 2;
  localparam int TIMEOUT  = 4;

  localparam logic [31:0] W15 = 32'hEE11_0F10;
  localparam logic [31:0] W14 = 32'hEE1E_0E10;
  localparam logic [31:0] W7  = 32'hEE11_0710;

  // ctl = {done, undef, cp_dav[1], cp_dav[0], cp_flush}
  typedef struct packed {
    logic [4:0]    ctl;
    logic [31:0]   word;
    logic [RW-1:0] rg;
    logic [31:0]   mode;
  } exp_t;

  logic              i_clk;
  logic              i_reset_n;
  logic              i_flush;
  logic              i_copro_dav;
  logic [31:0]       i_copro_word;
  logic [RW-1:0]     i_copro_reg;
  logic [31:0]       i_copro_mode;
  logic              o_copro_done;
  logic              o_copro_undef;
  logic [NUM_CP-1:0] o_cp_dav;
  logic [31:0]       o_cp_word;
  logic [RW-1:0]     o_cp_reg;
  logic [31:0]       o_cp_mode;
  logic              o_cp_flush;
  logic [NUM_CP-1:0] i_cp_done;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  zap_copro_arbiter #(
    .PHY_REGS (PHY_REGS),
    .NUM_CP   (NUM_CP),
    .CP_IDS   ({4'd14, 4'd15}),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_flush       (i_flush),
    .i_copro_dav   (i_copro_dav),
    .i_copro_word  (i_copro_word),
    .i_copro_reg   (i_copro_reg),
    .i_copro_mode  (i_copro_mode),
    .o_copro_done  (o_copro_done),
    .o_copro_undef (o_copro_undef),
    .o_cp_dav      (o_cp_dav),
    .o_cp_word     (o_cp_word),
    .o_cp_reg      (o_cp_reg),
    .o_cp_mode     (o_cp_mode),
    .o_cp_flush    (o_cp_flush),
    .i_cp_done     (i_cp_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic exp_t observed();
    exp_t o;
    o.ctl  = {o_copro_done, o_copro_undef, o_cp_dav, o_cp_flush};
    o.word = o_cp_word;
    o.rg   = o_cp_reg;
    o.mode = o_cp_mode;
    return o;
  endfunction

  task automatic push_exp(input logic [4:0] ctl, input logic [31:0] w,
                          input logic [RW-1:0] r, input logic [31:0] m);
    exp_t e;
    e.ctl  = ctl;
    e.word = w;
    e.rg   = r;
    e.mode = m;
    exp_q.push_back(e);
  endtask

  // stim = {copro_dav, cp_done[1:0], flush}
  task automatic apply(input logic [3:0] s);
    i_copro_dav = s[3];
    i_cp_done   = s[2:1];
    i_flush     = s[0];
  endtask

  task automatic test_reset();
    exp_t e, o;
    push_exp(5'b00000, '0, '0, '0);
    #3;
    e = exp_q.pop_front();
    o = observed();
    n_vec++;
    if (o !== e) begin
      n_miss++;
      $display("FAIL reset got ctl=%b w=%h r=%h m=%h exp ctl=%b w=%h r=%h m=%h",
               o.ctl, o.word, o.rg, o.mode, e.ctl, e.word, e.rg, e.mode);
    end
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  // CP15 on port 0; completion arrives in the fourth WAIT cycle, exactly
  // when the counter reaches TIMEOUT-1, so completion must win over timeout.
  task automatic test_mapped_cp15();
    logic [3:0] stim [7] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000,
                             4'b1010, 4'b1000, 4'b0000};
    logic [4:0] ctl  [7] = '{5'b00010, 5'b00010, 5'b00010, 5'b00010,
                             5'b10000, 5'b10000, 5'b00000};
    exp_t e, o;
    i_copro_word = W15;
    i_copro_reg  = 6'd13;
    i_copro_mode = 32'h6000_00D3;
    for (int c = 0; c < 7; c++) push_exp(ctl[c], W15, 6'd13, 32'h6000_00D3);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin
        // Later input changes must not disturb the latched transaction.
        i_copro_word = ~W15;
        i_copro_reg  = 6'd2;
        i_copro_mode = 32'h0;
      end
      apply(stim[c]);
      @(posedge i_clk);
      @(negedge i_clk);
      e = exp_q.pop_front();
      o = observed();
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL mapped_cp15 c%0d got ctl=%b w=%h r=%h m=%h exp ctl=%b w=%h r=%h m=%h",
                 c, o.ctl, o.word, o.rg, o.mode, e.ctl, e.word, e.rg, e.mode);
      end
    end
  endtask

  task automatic test_unmapped_cp7();
    logic [3:0] stim [3] = '{4'b1000, 4'b1000, 4'b0000};
    logic [4:0] ctl  [3] = '{5'b11000, 5'b11000, 5'b00000};
    exp_t e, o;
    i_copro_word = W7;
    i_copro_reg  = 6'd45;
    i_copro_mode = 32'h0000_0010;
    for (int c = 0; c < 3; c++) push_exp(ctl[c], W7, 6'd45, 32'h0000_0010);
    for (int c = 0; c < 3; c++) begin
      apply(stim[c]);
      @(posedge i_clk);
      @(negedge i_clk);
      e = exp_q.pop_front();
      o = observed();
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL unmapped_cp7 c%0d got ctl=%b w=%h r=%h m=%h exp ctl=%b w=%h r=%h m=%h",
                 c, o.ctl, o.word, o.rg, o.mode, e.ctl, e.word, e.rg, e.mode);
      end
    end
  endtask

  // CP14 on port 1 never answers; completions from port 0 must be ignored.
  task automatic test_timeout();
    logic [3:0] stim [7] = '{4'b1000, 4'b1010, 4'b1010, 4'b1010,
                             4'b1000, 4'b1000, 4'b0000};
    logic [4:0] ctl  [7] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100,
                             5'b11001, 5'b11000, 5'b00000};
    exp_t e, o;
    i_copro_word = W14;
    i_copro_reg  = 6'd1;
    i_copro_mode = 32'h0000_001F;
    for (int c = 0; c < 7; c++) push_exp(ctl[c], W14, 6'd1, 32'h0000_001F);
    for (int c = 0; c < 7; c++) begin
      apply(stim[c]);
      @(posedge i_clk);
      @(negedge i_clk);
      e = exp_q.pop_front();
      o = observed();
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL timeout c%0d got ctl=%b w=%h r=%h m=%h exp ctl=%b w=%h r=%h m=%h",
                 c, o.ctl, o.word, o.rg, o.mode, e.ctl, e.word, e.rg, e.mode);
      end
    end
  endtask

  // Flush in WAIT, then dav+flush together in IDLE (must not dispatch),
  // then a normal dispatch and completion.
  task automatic test_flush_wait();
    logic [3:0] stim [7] = '{4'b1000, 4'b1001, 4'b1001, 4'b1000,
                             4'b1010, 4'b1000, 4'b0000};
    logic [4:0] ctl  [7] = '{5'b00010, 5'b00001, 5'b00000, 5'b00010,
                             5'b10000, 5'b10000, 5'b00000};
    logic       live [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_t e, o;
    i_copro_word = W15;
    i_copro_reg  = 6'd7;
    i_copro_mode = 32'h8000_0013;
    for (int c = 0; c < 7; c++) begin
      if (live[c]) push_exp(ctl[c], W15, 6'd7, 32'h8000_0013);
      else         push_exp(ctl[c], '0, '0, '0);
    end
    for (int c = 0; c < 7; c++) begin
      apply(stim[c]);
      @(posedge i_clk);
      @(negedge i_clk);
      e = exp_q.pop_front();
      o = observed();
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL flush_wait c%0d got ctl=%b w=%h r=%h m=%h exp ctl=%b w=%h r=%h m=%h",
                 c, o.ctl, o.word, o.rg, o.mode, e.ctl, e.word, e.rg, e.mode);
      end
    end
  endtask

  // Predecode keeps dav high for five cycles while done is asserted.
  task automatic test_stalled_resp();
    logic [3:0] stim [8] = '{4'b1000, 4'b1010, 4'b1000, 4'b1000,
                             4'b1000, 4'b1000, 4'b1000, 4'b0000};
    logic [4:0] ctl  [8] = '{5'b00010, 5'b10000, 5'b10000, 5'b10000,
                             5'b10000, 5'b10000, 5'b10000, 5'b00000};
    exp_t e, o;
    i_copro_word = W15;
    i_copro_reg  = 6'd0;
    i_copro_mode = 32'h0000_0010;
    for (int c = 0; c < 8; c++) push_exp(ctl[c], W15, 6'd0, 32'h0000_0010);
    for (int c = 0; c < 8; c++) begin
      apply(stim[c]);
      @(posedge i_clk);
      @(negedge i_clk);
      e = exp_q.pop_front();
      o = observed();
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL stalled_resp c%0d got ctl=%b w=%h r=%h m=%h exp ctl=%b w=%h r=%h m=%h",
                 c, o.ctl, o.word, o.rg, o.mode, e.ctl, e.word, e.rg, e.mode);
      end
    end
  endtask

  // Flush while in RESP clears done/undef without an abort pulse.
  task automatic test_flush_resp();
    logic [3:0] stim [3] = '{4'b1000, 4'b1001, 4'b0000};
    logic [4:0] ctl  [3] = '{5'b11000, 5'b00000, 5'b00000};
    exp_t e, o;
    i_copro_word = W7;
    i_copro_reg  = 6'd9;
    i_copro_mode = 32'h0000_0011;
    push_exp(ctl[0], W7, 6'd9, 32'h0000_0011);
    push_exp(ctl[1], '0, '0, '0);
    push_exp(ctl[2], '0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      apply(stim[c]);
      @(posedge i_clk);
      @(negedge i_clk);
      e = exp_q.pop_front();
      o = observed();
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL flush_resp c%0d got ctl=%b w=%h r=%h m=%h exp ctl=%b w=%h r=%h m=%h",
                 c, o.ctl, o.word, o.rg, o.mode, e.ctl, e.word, e.rg, e.mode);
      end
    end
  endtask

  // Reset dropped between edges while a CP14 request is outstanding; then
  // a fresh dispatch and a flush from WAIT.
  task automatic test_async_reset();
    exp_t e, o;
    i_copro_word = W14;
    i_copro_reg  = 6'd33;
    i_copro_mode = 32'h0000_001B;
    push_exp(5'b00100, W14, 6'd33, 32'h0000_001B);
    push_exp(5'b00000, '0, '0, '0);
    push_exp(5'b00000, '0, '0, '0);
    push_exp(5'b00100, W14, 6'd33, 32'h0000_001B);
    push_exp(5'b00001, '0, '0, '0);
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin
          apply(4'b1000);
          @(posedge i_clk);
          @(negedge i_clk);
        end
        1: begin
          #2;
          i_reset_n = 1'b0;
          apply(4'b0000);
          #1;
        end
        2: begin
          @(negedge i_clk);
          i_reset_n = 1'b1;
          @(posedge i_clk);
          @(negedge i_clk);
        end
        3: begin
          apply(4'b1000);
          @(posedge i_clk);
          @(negedge i_clk);
        end
        default: begin
          apply(4'b0001);
          @(posedge i_clk);
          @(negedge i_clk);
        end
      endcase
      e = exp_q.pop_front();
      o = observed();
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL async_reset c%0d got ctl=%b w=%h r=%h m=%h exp ctl=%b w=%h r=%h m=%h",
                 c, o.ctl, o.word, o.rg, o.mode, e.ctl, e.word, e.rg, e.mode);
      end
    end
    apply(4'b0000);
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    i_reset_n    = 1'b0;
    i_flush      = 1'b0;
    i_copro_dav  = 1'b0;
    i_copro_word = '0;
    i_copro_reg  = '0;
    i_copro_mode = '0;
    i_cp_done    = '0;

    test_reset();
    test_mapped_cp15();
    test_unmapped_cp7();
    test_timeout();
    test_flush_wait();
    test_stalled_resp();
    test_flush_resp();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
